// File: rtl/cp0_timer_int_if.sv
// Pipeline-side bundle for the coprocessor 0 block: MTC0/MFC0 access,
// WB exception/eret requests, hardware interrupt lines and the status/redirect outputs.
interface cp0_timer_int_if #(parameter int NUM_HW_INT = 6);
  logic                  cp0_we;
  logic [4:0]            cp0_addr;
  logic [31:0]           cp0_wdata;
  logic [31:0]           cp0_rdata;
  logic                  ex_in;
  logic [4:0]            ex_code_in;
  logic [31:0]           ex_pc_in;
  logic                  ex_bd_in;
  logic [31:0]           ex_badvaddr_in;
  logic                  eret_in;
  logic [NUM_HW_INT-1:0] hw_int_in;
  logic                  int_req;
  logic                  timer_int;
  logic                  flush;
  logic [31:0]           redirect_pc;
  logic                  hlt;
  logic                  ie;
  logic                  exl;
  logic [7:0]            int_mask;

  modport master (
    output cp0_we, cp0_addr, cp0_wdata, ex_in, ex_code_in, ex_pc_in, ex_bd_in,
           ex_badvaddr_in, eret_in, hw_int_in,
    input  cp0_rdata, int_req, timer_int, flush, redirect_pc, hlt, ie, exl, int_mask
  );

  modport slave (
    input  cp0_we, cp0_addr, cp0_wdata, ex_in, ex_code_in, ex_pc_in, ex_bd_in,
           ex_badvaddr_in, eret_in, hw_int_in,
    output cp0_rdata, int_req, timer_int, flush, redirect_pc, hlt, ie, exl, int_mask
  );
endinterface

// File: rtl/cp0_timer_int.sv
// Coprocessor 0 for the pipelined MIPS core: STATUS/CAUSE/EPC/BadVAddr, COUNT/COMPARE
// timer interrupt, masked interrupt request, flush/redirect and a RUN/HALT state machine.
module cp0_timer_int #(
  parameter int          NUM_HW_INT  = 6,
  parameter bit          TIMER_EN    = 1'b1,
  parameter logic [31:0] EX_ENTRY_PC = 32'h0040_0008,
  parameter logic [31:0] HLT_PC      = 32'h0040_0008
) (
  input logic            clk,
  input logic            rst,
  cp0_timer_int_if.slave bus
);
  localparam logic [4:0] A_BADV = 5'd8, A_COUNT = 5'd9, A_COMPARE = 5'd11,
                         A_STATUS = 5'd12, A_CAUSE = 5'd13, A_EPC = 5'd14;
  localparam logic [4:0] EXC_HLT = 5'd1, EXC_RESUME = 5'd2, EXC_ADEL = 5'd4, EXC_ADES = 5'd5;

  typedef enum logic {RUN, HALT} state_t;

  state_t      state;
  logic        hlt_q;
  logic [7:0]  im;
  logic        exl_q, ie_q, ti, bd, toggle;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  exc_code;
  logic [31:0] epc, badvaddr, count, compare;
  logic [5:0]  hw_ext;
  logic [7:0]  ip;
  logic        wr_badv, wr_count, wr_compare, wr_status, wr_cause, wr_epc, addr_fault;

  always_comb begin
    hw_ext = '0;
    hw_ext[NUM_HW_INT-1:0] = bus.hw_int_in;
  end

  assign wr_badv    = bus.cp0_we && (bus.cp0_addr == A_BADV);
  assign wr_count   = bus.cp0_we && (bus.cp0_addr == A_COUNT);
  assign wr_compare = bus.cp0_we && (bus.cp0_addr == A_COMPARE);
  assign wr_status  = bus.cp0_we && (bus.cp0_addr == A_STATUS);
  assign wr_cause   = bus.cp0_we && (bus.cp0_addr == A_CAUSE);
  assign wr_epc     = bus.cp0_we && (bus.cp0_addr == A_EPC);
  assign addr_fault = bus.ex_in && (bus.ex_code_in == EXC_ADEL || bus.ex_code_in == EXC_ADES);

  // TI is folded into IP7 on read so the timer bit tracks TI without an extra cycle
  assign ip = {ip_hw[5] | (TIMER_EN & ti), ip_hw[4:0], ip_sw};

  always_ff @(posedge clk) begin
    if (rst) begin
      im       <= 8'hFF;
      exl_q    <= 1'b0;
      ie_q     <= 1'b0;
      ip_hw    <= '0;
      ip_sw    <= '0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= EX_ENTRY_PC;
      badvaddr <= '0;
    end else begin
      ip_hw <= hw_ext;
      if (wr_cause) ip_sw <= bus.cp0_wdata[9:8];
      if (wr_status) begin
        im   <= bus.cp0_wdata[15:8];
        ie_q <= bus.cp0_wdata[0];
      end
      // exception beats eret beats MTC0 for EXL/EPC; other MTC0 fields still land
      if (bus.ex_in) begin
        exl_q    <= 1'b1;
        bd       <= bus.ex_bd_in;
        exc_code <= bus.ex_code_in;
        if (bus.ex_code_in != EXC_RESUME)
          epc <= bus.ex_bd_in ? bus.ex_pc_in - 32'd4 : bus.ex_pc_in;
      end else if (bus.eret_in) begin
        exl_q <= 1'b0;
      end else begin
        if (wr_status) exl_q <= bus.cp0_wdata[1];
        if (wr_epc)    epc   <= bus.cp0_wdata;
      end
      if (addr_fault)   badvaddr <= bus.ex_badvaddr_in;
      else if (wr_badv) badvaddr <= bus.cp0_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      compare <= '0;
      toggle  <= 1'b0;
      ti      <= 1'b0;
    end else if (TIMER_EN) begin
      if (wr_count) begin
        count  <= bus.cp0_wdata;
        toggle <= 1'b0;
      end else begin
        toggle <= ~toggle;
        if (toggle) count <= count + 32'd1;
      end
      if (wr_compare) begin
        compare <= bus.cp0_wdata;
        ti      <= 1'b0;
      end else if (count == compare && compare != '0) begin
        ti <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      hlt_q <= 1'b0;
    end else begin
      case (state)
        RUN:
          if (bus.ex_in && bus.ex_code_in == EXC_HLT) begin
            state <= HALT;
            hlt_q <= 1'b1;
          end
        HALT:
          if (bus.ex_in && bus.ex_code_in == EXC_RESUME) begin
            state <= RUN;
            hlt_q <= 1'b0;
          end
        default: begin
          state <= RUN;
          hlt_q <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      A_BADV:    bus.cp0_rdata = badvaddr;
      A_COUNT:   bus.cp0_rdata = TIMER_EN ? count : '0;
      A_COMPARE: bus.cp0_rdata = TIMER_EN ? compare : '0;
      A_STATUS:  bus.cp0_rdata = {16'h0040, im, 6'h0, exl_q, ie_q};
      A_CAUSE:   bus.cp0_rdata = {bd, ti, 14'h0, ip, 1'b0, exc_code, 2'b0};
      A_EPC:     bus.cp0_rdata = epc;
      default:   bus.cp0_rdata = '0;
    endcase
  end

  assign bus.int_req     = ie_q & ~exl_q & ~hlt_q & (|(ip & im));
  assign bus.timer_int   = ti;
  assign bus.flush       = bus.ex_in | bus.eret_in;
  assign bus.redirect_pc = bus.ex_in ? EX_ENTRY_PC : bus.eret_in ? epc : hlt_q ? HLT_PC : epc;
  assign bus.hlt         = hlt_q;
  assign bus.ie          = ie_q;
  assign bus.exl         = exl_q;
  assign bus.int_mask    = im;
endmodule

// File: tb/tb_cp0_timer_int.sv
// Directed and random stimulus for cp0_timer_int against an arithmetic reference model:
// COUNT is derived from the cycles elapsed since its last load rather than stepped per cycle.
module tb_cp0_timer_int;
  localparam logic [31:0] EX_ENTRY_PC = 32'h0040_0008;
  localparam logic [31:0] HLT_PC      = 32'h0040_0008;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #10 clk = ~clk;

  cp0_timer_int_if #(.NUM_HW_INT(6)) bus ();
  cp0_timer_int #(.NUM_HW_INT(6), .TIMER_EN(1'b1), .EX_ENTRY_PC(EX_ENTRY_PC), .HLT_PC(HLT_PC))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [7:0]  m_im = 8'hFF;
  logic        m_ie = 0, m_exl = 0, m_ti = 0, m_bd = 0, m_halt = 0;
  logic [4:0]  m_code = 0;
  logic [5:0]  m_hw = 0;
  logic [1:0]  m_sw = 0;
  logic [31:0] m_epc = EX_ENTRY_PC, m_bad = 0, m_base = 0, m_cmp = 0;
  longint      m_cyc = 0, m_load_cyc = 0;

  logic [4:0] rd_addrs [7] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd3};
  logic [4:0] wr_addrs [8] = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};
  logic [4:0] codes    [9] = '{5'd0, 5'd1, 5'd2, 5'd4, 5'd5, 5'd8, 5'd9, 5'd10, 5'd12};

  function automatic logic [31:0] m_count();
    return m_base + 32'((m_cyc - m_load_cyc) / 2);
  endfunction

  function automatic logic [7:0] m_ip();
    return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
  endfunction

  function automatic logic m_int_req();
    return m_ie && !m_exl && !m_halt && ((m_ip() & m_im) != 8'h00);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_bad;
      5'd9:    return m_count();
      5'd11:   return m_cmp;
      5'd12:   return {16'h0040, m_im, 6'h0, m_exl, m_ie};
      5'd13:   return {m_bd, m_ti, 14'h0, m_ip(), 1'b0, m_code, 2'b0};
      5'd14:   return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
    bus.cp0_addr = a;
    #1;
    chk(tag, bus.cp0_rdata, exp);
  endtask

  // Applies the inputs currently driven to the model for one clock edge.
  task automatic m_step();
    logic [31:0] cnt, d;
    logic        tiset, wr;
    logic [4:0]  a;
    cnt   = m_count();
    tiset = (cnt == m_cmp) && (m_cmp != 0);
    wr    = bus.cp0_we;
    a     = bus.cp0_addr;
    d     = bus.cp0_wdata;
    m_cyc++;
    if (rst) begin
      m_im = 8'hFF; m_ie = 0; m_exl = 0; m_ti = 0; m_bd = 0; m_halt = 0; m_code = 0;
      m_hw = 0; m_sw = 0; m_epc = EX_ENTRY_PC; m_bad = 0; m_cmp = 0;
      m_base = 0; m_load_cyc = m_cyc;
      return;
    end
    m_hw = bus.hw_int_in;
    if (wr && a == 5'd13) m_sw = d[9:8];
    if (wr && a == 5'd12) begin m_im = d[15:8]; m_ie = d[0]; end
    if (bus.ex_in) begin
      m_exl  = 1;
      m_bd   = bus.ex_bd_in;
      m_code = bus.ex_code_in;
      if (bus.ex_code_in != 5'd2) m_epc = bus.ex_bd_in ? bus.ex_pc_in - 32'd4 : bus.ex_pc_in;
      if (bus.ex_code_in == 5'd1) m_halt = 1;
      if (bus.ex_code_in == 5'd2) m_halt = 0;
    end else if (bus.eret_in) begin
      m_exl = 0;
    end else begin
      if (wr && a == 5'd12) m_exl = d[1];
      if (wr && a == 5'd14) m_epc = d;
    end
    if (bus.ex_in && (bus.ex_code_in == 5'd4 || bus.ex_code_in == 5'd5)) m_bad = bus.ex_badvaddr_in;
    else if (wr && a == 5'd8) m_bad = d;
    if (wr && a == 5'd9) begin m_base = d; m_load_cyc = m_cyc; end
    if (wr && a == 5'd11) begin m_cmp = d; m_ti = 0; end
    else if (tiset) m_ti = 1;
  endtask

  task automatic cyc();
    logic [31:0] exp_redir;
    #1;
    if (!rst) begin
      exp_redir = bus.ex_in ? EX_ENTRY_PC : bus.eret_in ? m_epc : m_halt ? HLT_PC : m_epc;
      chk("flush", 32'(bus.flush), 32'(bus.ex_in | bus.eret_in));
      chk("redirect_pc", bus.redirect_pc, exp_redir);
    end
    m_step();
    @(posedge clk);
    #1;
    bus.cp0_we = 0; bus.ex_in = 0; bus.eret_in = 0;
    chk("int_req", 32'(bus.int_req), 32'(m_int_req()));
    chk("hlt", 32'(bus.hlt), 32'(m_halt));
    chk("ie", 32'(bus.ie), 32'(m_ie));
    chk("exl", 32'(bus.exl), 32'(m_exl));
    chk("int_mask", 32'(bus.int_mask), 32'(m_im));
    chk("timer_int", 32'(bus.timer_int), 32'(m_ti));
    for (int i = 0; i < 7; i++) rd(rd_addrs[i], $sformatf("rd%0d", rd_addrs[i]), m_read(rd_addrs[i]));
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.cp0_we = 1; bus.cp0_addr = a; bus.cp0_wdata = d;
    cyc();
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bdv,
                     input logic [31:0] badv);
    bus.ex_in = 1; bus.ex_code_in = code; bus.ex_pc_in = pc; bus.ex_bd_in = bdv;
    bus.ex_badvaddr_in = badv;
    cyc();
  endtask

  initial begin
    int waited;
    bus.cp0_we = 0; bus.cp0_addr = 0; bus.cp0_wdata = 0; bus.ex_in = 0; bus.ex_code_in = 0;
    bus.ex_pc_in = 0; bus.ex_bd_in = 0; bus.ex_badvaddr_in = 0; bus.eret_in = 0; bus.hw_int_in = 0;

    rst = 1; cyc(); cyc(); rst = 0; cyc();
    rd(5'd12, "status_rst", 32'h0040_FF00);
    rd(5'd13, "cause_rst", 32'h0);
    rd(5'd14, "epc_rst", 32'h0040_0008);
    chk("hlt_rst", 32'(bus.hlt), 32'h0);
    chk("int_req_rst", 32'(bus.int_req), 32'h0);

    // hardware interrupt through IM/IE, masked by EXL, restored by ERET
    mtc0(5'd12, 32'h0000_0401);
    bus.hw_int_in = 6'h01;
    cyc();
    chk("int_req_hw", 32'(bus.int_req), 32'h1);
    exc(5'd0, 32'h0040_0200, 1'b0, 32'h0);
    chk("exl_int", 32'(bus.exl), 32'h1);
    chk("int_req_exl", 32'(bus.int_req), 32'h0);
    bus.eret_in = 1; cyc();
    chk("exl_eret", 32'(bus.exl), 32'h0);
    chk("int_req_eret", 32'(bus.int_req), 32'h1);
    bus.hw_int_in = 6'h00; cyc(); cyc();
    chk("int_req_drop", 32'(bus.int_req), 32'h0);

    // timer interrupt, clear by COMPARE write, COUNT wrap
    mtc0(5'd9, 32'h0);
    mtc0(5'd11, 32'd10);
    waited = 0;
    while (!bus.timer_int && waited < 40) begin cyc(); waited++; end
    chk("ti_set", 32'(bus.timer_int), 32'h1);
    bus.cp0_addr = 5'd13; #1;
    chk("ip7", 32'(bus.cp0_rdata[15]), 32'h1);
    mtc0(5'd11, 32'h0);
    chk("ti_clear", 32'(bus.timer_int), 32'h0);
    mtc0(5'd9, 32'hFFFF_FFFF);
    cyc(); cyc();
    rd(5'd9, "count_wrap", 32'h0);

    // address error in a delay slot
    exc(5'd4, 32'h0040_0100, 1'b1, 32'h13);
    rd(5'd14, "epc_bd", 32'h0040_00FC);
    rd(5'd8, "badvaddr", 32'h13);
    rd(5'd13, "cause_adel", 32'h8000_0010);
    bus.eret_in = 1; cyc();

    // halt / resume
    exc(5'd1, 32'h0040_0300, 1'b0, 32'h0);
    chk("hlt_on", 32'(bus.hlt), 32'h1);
    chk("redirect_hlt", bus.redirect_pc, HLT_PC);
    rd(5'd14, "epc_hlt", 32'h0040_0300);
    exc(5'd2, 32'h0040_0400, 1'b0, 32'h0);
    chk("hlt_off", 32'(bus.hlt), 32'h0);
    rd(5'd14, "epc_resume", 32'h0040_0300);

    // exception + eret + MTC0 EPC in one cycle
    bus.eret_in = 1; bus.cp0_we = 1; bus.cp0_addr = 5'd14; bus.cp0_wdata = 32'h1234;
    exc(5'd8, 32'h0040_0500, 1'b0, 32'h0);
    chk("exl_prio", 32'(bus.exl), 32'h1);
    rd(5'd14, "epc_prio", 32'h0040_0500);

    // reset while halted
    exc(5'd1, 32'h0040_0600, 1'b0, 32'h0);
    chk("hlt_pre_rst", 32'(bus.hlt), 32'h1);
    rst = 1; cyc(); rst = 0;
    chk("hlt_post_rst", 32'(bus.hlt), 32'h0);
    rd(5'd12, "status_post_rst", 32'h0040_FF00);
    rd(5'd13, "cause_post_rst", 32'h0);
    rd(5'd14, "epc_post_rst", 32'h0040_0008);

    // random mix of MTC0, exceptions, eret and interrupt lines
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) bus.hw_int_in = 6'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        bus.cp0_we    = 1;
        bus.cp0_addr  = wr_addrs[$urandom_range(0, 7)];
        bus.cp0_wdata = $urandom;
        if (bus.cp0_addr == 5'd11 && $urandom_range(0, 1) == 0)
          bus.cp0_wdata = m_count() + 32'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 5) == 0) begin
        bus.ex_in          = 1;
        bus.ex_code_in     = codes[$urandom_range(0, 8)];
        bus.ex_pc_in       = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        bus.ex_bd_in       = 1'($urandom);
        bus.ex_badvaddr_in = $urandom;
      end
      if ($urandom_range(0, 5) == 0) bus.eret_in = 1;
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cp0_timer_int.md
Name: cp0_timer_int

Overview:
- Parametrised next-generation coprocessor 0 for the pipelined MIPS core.
- Holds STATUS, CAUSE, EPC, BadVAddr, COUNT and COMPARE.
- Adds a COUNT/COMPARE timer interrupt and a configurable number of hardware interrupt lines.
- Generates a masked interrupt request, flush/redirect signalling and a RUN/HALT state machine.
- Sits beside the WB stage; exception/eret requests arrive from WB, redirect PC goes to the fetch stage.

Parameters:
NUM_HW_INT, 6, number of hardware interrupt inputs (1..6), mapped to IP[2+NUM_HW_INT-1:2]; unused IP bits read 0
TIMER_EN, 1, 1 = COUNT/COMPARE timer present and ORed into IP7; 0 = COUNT/COMPARE read 0 and ignore writes
EX_ENTRY_PC, 32'h0040_0008, exception handler entry and EPC reset value
HLT_PC, 32'h0040_0008, redirect target while halted

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
cp0_we  input  1  MTC0 write enable
cp0_addr  input  5  register index: 8 BadVAddr, 9 COUNT, 11 COMPARE, 12 STATUS, 13 CAUSE, 14 EPC
cp0_wdata  input  32  MTC0 data
cp0_rdata  output  32  MFC0 data, combinational on cp0_addr; unmapped index returns 0
ex_in  input  1  exception taken in WB
ex_code_in  input  5  ExcCode: 0 INT, 1 HLT, 2 RESUME, 4 ADEL, 5 ADES, 8 SYS, 9 BP, 10 RI, 12 OV
ex_pc_in  input  32  PC of the excepting instruction
ex_bd_in  input  1  excepting instruction is in a branch delay slot
ex_badvaddr_in  input  32  faulting address for ADEL/ADES
eret_in  input  1  ERET in WB
hw_int_in  input  NUM_HW_INT  level hardware interrupts
int_req  output  1  interrupt pending to the pipeline
timer_int  output  1  CAUSE.TI
flush  output  1  ex_in | eret_in
redirect_pc  output  32  ex_in ? EX_ENTRY_PC : eret_in ? EPC : hlt ? HLT_PC : EPC
hlt  output  1  state == HALT
ie  output  1  STATUS.IE
exl  output  1  STATUS.EXL
int_mask  output  8  STATUS.IM

Behaviour:
- All state updates on posedge clk.
- Reset values: IM=8'hFF, EXL=0, IE=0, IP=0, TI=0, BD=0, ExcCode=0, EPC=EX_ENTRY_PC, BadVAddr=0, COUNT=0, COMPARE=0, count toggle=0, state RUN.
- All outputs follow from those reset values, e.g. hlt=0, int_req=0.
- Reset mid-halt or mid-timer returns all of the above to reset values in one cycle.

Register read formats:
- STATUS = {16'h0040, IM, 6'h0, EXL, IE}
- CAUSE = {BD, TI, 14'h0, IP[7:0], 1'b0, ExcCode, 2'b0}

Interrupt logic:
- IP[7:2] registered each cycle from zero-extended hw_int_in, giving 1 cycle latency.
- IP[7] additionally ORs TI when TIMER_EN=1.
- IP[1:0] written only by MTC0 CAUSE from wdata[9:8].
- int_req = IE & ~EXL & ~hlt & |(IP & IM), combinational from registered state.

Timer (TIMER_EN=1):
- Toggle bit flips every cycle; COUNT increments when toggle==1, i.e. every 2 cycles.
- COUNT wraps 32'hFFFF_FFFF -> 0 without a flag.
- When COUNT==COMPARE and COMPARE!=0, TI is set on the next edge and stays set.
- MTC0 COMPARE clears TI.
- MTC0 COUNT loads the value and clears the toggle; that load wins over the increment in the same cycle.

Exception (ex_in=1):
- EXL<=1, BD<=ex_bd_in, ExcCode<=ex_code_in.
- If code!=RESUME: EPC<=ex_bd_in ? ex_pc_in-4 : ex_pc_in.
- If code is ADEL/ADES: BadVAddr<=ex_badvaddr_in.

ERET (eret_in=1 and ex_in=0): EXL<=0.

Priority (same cycle):
- ex_in > eret_in > MTC0 for EXL/EPC.
- MTC0 to any other field still takes effect alongside ex_in.
- Simultaneous ex_in and eret_in is treated as exception only.

MTC0 write fields:
- STATUS: IM, EXL, IE from wdata bits [15:8], [1], [0].
- EPC, BadVAddr: full word.

State machine:
- RUN -> HALT on ex_in with code HLT.
- HALT -> RUN on ex_in with code RESUME.
- Other exceptions while HALT stay in HALT.
- HLT while already HALT has no state change.

Test Plan:
- Reset, then read STATUS, CAUSE, EPC -> 32'h0040FF00, 32'h0, 32'h0040_0008; hlt=0, int_req=0.
- IE=1, IM=8'h04, pulse hw_int_in[0] -> IP[2]=1 one cycle later; int_req=1; ex_in code 0 -> EXL=1, int_req=0; eret -> EXL=0, int_req=1 while the input is held.
- COMPARE=10, COUNT=0 -> TI sets about 20 cycles later; IP7=1, timer_int=1; write COMPARE=0 -> TI=0; COUNT=FFFF_FFFF wraps to 0.
- ex_in with ex_pc_in=32'h0040_0100, bd=1, code ADEL, badvaddr=32'h13 -> EPC=32'h0040_00FC, BadVAddr=32'h13, CAUSE=32'h8000_0010, redirect_pc=EX_ENTRY_PC.
- ex_in code HLT -> hlt=1, redirect_pc=HLT_PC, EPC updated; ex_in code RESUME -> hlt=0, EPC unchanged.
- ex_in and eret_in together with MTC0 EPC=32'h1234 -> EXL=1, EPC=ex_pc_in; assert rst while HALT -> RUN, all reset values restored.
